// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver slice.
package branch_resolver_pkg;

  // One in-flight prediction: predicted direction plus the PC to recover to
  // if that direction turns out to be wrong.
  typedef struct packed {
    logic        taken;
    logic [31:0] alt_pc;
  } bq_entry_t;

  localparam logic [31:0] COUNTER_MAX = 32'hFFFF_FFFF;

  // Statistics counters stick at their maximum instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == COUNTER_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Prediction/resolution bus between the pipeline and the branch resolver.
interface branch_resolver_if;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_alt_pc;
  logic        res_valid;
  logic        res_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_taken;
  logic        q_full;

  // Pipeline side: issues predictions and resolutions, consumes recovery info.
  modport master (
    output pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
    input  flush, redirect_pc, upd_valid, upd_taken, q_full
  );

  // Resolver side.
  modport slave (
    input  pred_valid, pred_taken, pred_alt_pc, res_valid, res_taken,
    output flush, redirect_pc, upd_valid, upd_taken, q_full
  );
endinterface

// File: rtl/branch_resolver_bq_fifo.sv
// In-order prediction queue: circular buffer with AW-bit pointers and an
// AW+1-bit occupancy count. Clear empties it and beats push/pop.
module bq_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  bq_entry_t      wr_data,
  output bq_entry_t      head,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);

  bq_entry_t      mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Entry storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolver.sv
// Completion end of the branch-prediction path: checks the oldest queued
// prediction against the execute outcome, flushes on a miss and keeps stats.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              stall,
  branch_resolver_if.slave  bus,
  output logic              err,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mis_cnt
);

  bq_entry_t   head;
  bq_entry_t   wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        pop;
  logic        mis;
  logic        push;
  logic        empty_res;
  logic        flush_r;
  logic        upd_valid_r;
  logic        upd_taken_r;
  logic [31:0] redirect_r;

  // A miss makes every younger entry wrong-path, so it also kills a same-cycle
  // enqueue. A correct pop frees a slot, which lets a full queue accept a push.
  always_comb begin
    pop       = bus.res_valid && !stall && !clr && !empty;
    mis       = pop && (head.taken ^ bus.res_taken);
    empty_res = bus.res_valid && !stall && !clr && empty;
    push      = bus.pred_valid && !stall && !clr && !mis && (!full || pop);
    wr_data   = '{taken: bus.pred_taken, alt_pc: bus.pred_alt_pc};
  end

  bq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (clr || mis),
    .wr_data (wr_data),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Registered pulses, recovery PC, training outcome, counters and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_r     <= 1'b0;
      upd_valid_r <= 1'b0;
      upd_taken_r <= 1'b0;
      redirect_r  <= '0;
      br_cnt      <= '0;
      mis_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      flush_r     <= mis;
      upd_valid_r <= pop;
      if (pop) begin
        upd_taken_r <= bus.res_taken;
        br_cnt      <= sat_inc(br_cnt);
      end
      if (mis) begin
        redirect_r <= head.alt_pc;
        mis_cnt    <= sat_inc(mis_cnt);
      end
      if (empty_res) err <= 1'b1;
    end
  end

  assign bus.flush       = flush_r;
  assign bus.upd_valid   = upd_valid_r;
  assign bus.upd_taken   = upd_taken_r;
  assign bus.redirect_pc = redirect_r;
  assign bus.q_full      = full;

endmodule
